// File: rtl/buffer_read_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | buffer_read_scheduler_pkg                                            |
// | Shared FSM encoding and id-width helper for the buffer schedulers.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package buffer_read_scheduler_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  // Requester-id width; a lone requester still gets a 1-bit id field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/buffer_read_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | buffer_read_scheduler_if                                             |
// | Requester, RAM read-port and response bundle of the read scheduler. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface buffer_read_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [ADDR_W-1:0]         ram_raddr;
  logic [DATA_W-1:0]         ram_rdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_last;
  logic                      busy;

  modport master (
    output req_valid, req_addr, req_len, ram_rdata,
    input  req_ready, ram_raddr, rsp_valid, rsp_data, rsp_last, busy
  );

  modport slave (
    input  req_valid, req_addr, req_len, ram_rdata,
    output req_ready, ram_raddr, rsp_valid, rsp_data, rsp_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/buffer_read_scheduler_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Combinational round-robin pick: first request at or above pointer.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          gnt_valid_o,
  output logic [IW-1:0] gnt_id_o
);

  int idx;

  // Scan from the far end down so the candidate nearest the pointer wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id_o    = '0;
    idx         = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (req_i[IW'(idx)]) begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = IW'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/buffer_read_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | buffer_read_scheduler                                                |
// | Round-robin burst scheduler for the buffer RAM read port.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module buffer_read_scheduler
  import buffer_read_scheduler_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 8,
  parameter int RD_LATENCY = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  buffer_read_scheduler_if.slave bus
);

  localparam int ID_W = id_width(NUM_REQ);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d, gid_q, gid_d;
  logic [ADDR_W-1:0]   base_q, base_d, raddr_q, raddr_d;
  logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d;
  logic                push_vld, push_last;
  logic                gnt_valid;
  logic [ID_W-1:0]     gnt_id;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [LEN_W-1:0]    len_arr  [NUM_REQ];
  logic [RD_LATENCY:0] pipe_vld;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic                rsp_last_q;
  logic [DATA_W-1:0]   rsp_data_q;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign addr_arr[r] = bus.req_addr[r*ADDR_W +: ADDR_W];
    assign len_arr[r]  = bus.req_len[r*LEN_W +: LEN_W];
  end

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req_i       (bus.req_valid),
    .ptr_i       (ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    base_d    = base_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    raddr_d   = raddr_q;
    ready_d   = '0;
    push_vld  = 1'b0;
    push_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          ready_d = NUM_REQ'(1) << gnt_id;
          base_d  = addr_arr[gnt_id];
          len_d   = len_arr[gnt_id];
          gid_d   = gnt_id;
          cnt_d   = '0;
          ptr_d   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        raddr_d   = base_q + ADDR_W'(cnt_q);
        push_vld  = 1'b1;
        push_last = (cnt_q == len_q);
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == len_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      raddr_q <= '0;
      ready_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
      ready_q <= ready_d;
    end
  end

  // One stage for the address register plus one per RAM latency cycle.
  for (genvar s = 0; s <= RD_LATENCY; s++) begin : g_stage
    logic            vld_q, last_q, vld_in, last_in;
    logic [ID_W-1:0] id_q, id_in;
    if (s == 0) begin : g_head
      assign vld_in  = push_vld;
      assign last_in = push_last;
      assign id_in   = gid_q;
    end else begin : g_link
      assign vld_in  = g_stage[s-1].vld_q;
      assign last_in = g_stage[s-1].last_q;
      assign id_in   = g_stage[s-1].id_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
        id_q   <= '0;
      end else begin
        vld_q  <= vld_in;
        last_q <= last_in;
        id_q   <= id_in;
      end
    end
    assign pipe_vld[s] = vld_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= g_stage[RD_LATENCY].vld_q ? (NUM_REQ'(1) << g_stage[RD_LATENCY].id_q) : '0;
      rsp_last_q  <= g_stage[RD_LATENCY].vld_q & g_stage[RD_LATENCY].last_q;
      rsp_data_q  <= bus.ram_rdata;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.ram_raddr = raddr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_data  = rsp_data_q;
  // The response register counts as in flight so busy covers the last word.
  assign bus.busy      = (state_q == S_BURST) | (|pipe_vld) | (|rsp_valid_q);

endmodule
`default_nettype wire

// File: tb/tb_buffer_read_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_buffer_read_scheduler                                             |
// | Directed bench: RD_LATENCY=1 instance (a) and RD_LATENCY=3 (b).     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_buffer_read_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic [3:0]  drv_valid;
  logic [31:0] drv_addr, drv_len;

  buffer_read_scheduler_if #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .LEN_W(8)) a_if ();
  buffer_read_scheduler_if #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .LEN_W(8)) b_if ();

  buffer_read_scheduler #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .LEN_W(8), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  buffer_read_scheduler #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .LEN_W(8), .RD_LATENCY(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  assign a_if.req_valid = sel ? 4'b0 : drv_valid;
  assign b_if.req_valid = sel ? drv_valid : 4'b0;
  assign a_if.req_addr  = drv_addr;
  assign b_if.req_addr  = drv_addr;
  assign a_if.req_len   = drv_len;
  assign b_if.req_len   = drv_len;

  // RAM preloaded with addr^0xA5, one-cycle and three-cycle read latency.
  logic [7:0] a_rd, b_rd1, b_rd2, b_rd3;
  always @(posedge clk) begin
    a_rd  <= a_if.ram_raddr ^ 8'hA5;
    b_rd1 <= b_if.ram_raddr ^ 8'hA5;
    b_rd2 <= b_rd1;
    b_rd3 <= b_rd2;
  end
  assign a_if.ram_rdata = a_rd;
  assign b_if.ram_rdata = b_rd3;

  logic [3:0] o_ready, o_rvalid;
  logic [7:0] o_raddr, o_rdata;
  logic       o_rlast, o_busy;
  assign o_ready  = sel ? b_if.req_ready : a_if.req_ready;
  assign o_rvalid = sel ? b_if.rsp_valid : a_if.rsp_valid;
  assign o_raddr  = sel ? b_if.ram_raddr : a_if.ram_raddr;
  assign o_rdata  = sel ? b_if.rsp_data  : a_if.rsp_data;
  assign o_rlast  = sel ? b_if.rsp_last  : a_if.rsp_last;
  assign o_busy   = sel ? b_if.busy      : a_if.busy;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".ready"}, o_ready, 0);
    chk({name, ".raddr"}, o_raddr, 0);
    chk({name, ".rvalid"}, o_rvalid, 0);
    chk({name, ".rdata"}, o_rdata, 0);
    chk({name, ".rlast"}, o_rlast, 0);
    chk({name, ".busy"}, o_busy, 0);
  endtask

  // Waits (bounded) for a ready pulse at a negedge and checks which one.
  task automatic wait_grant(input string name, input logic [3:0] exp);
    bit got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (o_ready != 4'b0) got = 1;
    end
    chk(name, o_ready, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv_valid = 4'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         id;
    logic [7:0] addr;
    logic [7:0] len;
    bit         use_b;
    int         lat;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int len;
    int j;
    sel = v.use_b;
    len = int'(v.len);
    @(posedge clk); #1;
    drv_valid = 4'b1 << v.id;
    drv_addr[v.id*8 +: 8] = v.addr;
    drv_len[v.id*8 +: 8]  = v.len;
    wait_grant("vec.grant", 4'b1 << v.id);
    @(posedge clk); #1;
    drv_valid = 4'b0;
    for (int k = 1; k <= len + v.lat + 3; k++) begin
      @(negedge clk);
      if (k == 1) chk("vec.ready_pulse", o_ready, 0);
      if (k <= len + 1) chk("vec.raddr", o_raddr, (int'(v.addr) + k - 1) & 8'hFF);
      j = k - v.lat - 2;
      if (j >= 0 && j <= len) begin
        chk("vec.rvalid", o_rvalid, 1 << v.id);
        chk("vec.rdata", o_rdata, ((int'(v.addr) + j) & 8'hFF) ^ 8'hA5);
        chk("vec.rlast", o_rlast, (j == len) ? 1 : 0);
        if (j == 0)   chk("vec.first", o_rdata, v.exp_first);
        if (j == len) chk("vec.last", o_rdata, v.exp_last);
      end else begin
        chk("vec.rvalid_idle", o_rvalid, 0);
      end
      chk("vec.busy", o_busy, (k <= v.lat + 2 + len) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] gnt [5];
    int         gcyc [5];
    int         n;
    int         off [4];
    logic [7:0] base [4];
    logic [3:0] pend;
    int         rid;

    sel = 1'b0; drv_valid = '0; drv_addr = '0; drv_len = '0; rst_n = 1'b0;
    //            id addr   len   b  lat first  last
    vecs[0] = '{0, 8'h10, 8'd3, 0, 1, 8'hB5, 8'hB6};
    vecs[1] = '{2, 8'hFE, 8'd3, 0, 1, 8'h5B, 8'hA4};
    vecs[2] = '{1, 8'h40, 8'd7, 1, 3, 8'hE5, 8'hE2};
    vecs[3] = '{3, 8'h80, 8'd0, 0, 1, 8'h25, 8'h25};
    vecs[4] = '{1, 8'h00, 8'd1, 0, 1, 8'hA5, 8'hA4};
    vecs[5] = '{2, 8'hFF, 8'd0, 1, 3, 8'h5A, 8'h5A};

    // Reset state of both instances while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    sel = 1'b0; #1 chk_all_zero("reset_a");
    sel = 1'b1; #1 chk_all_zero("reset_b");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // All four requesting, len=0: strict rotation, one bubble between grants.
    sel = 1'b0;
    do_reset();
    foreach (gnt[i]) begin gnt[i] = '0; gcyc[i] = 0; end
    n = 0;
    @(posedge clk); #1;
    drv_addr = 32'h60402000;
    drv_len  = 32'h0;
    drv_valid = 4'hF;
    for (int t = 0; t < 40 && n < 5; t++) begin
      @(negedge clk);
      if (o_rvalid != 4'b0) chk("rr.rlast", o_rlast, 1);
      if (o_ready != 4'b0) begin
        gnt[n] = o_ready;
        gcyc[n] = t;
        n++;
      end
    end
    @(posedge clk); #1;
    drv_valid = 4'b0;
    chk("rr.g0", gnt[0], 4'b0001);
    chk("rr.g1", gnt[1], 4'b0010);
    chk("rr.g2", gnt[2], 4'b0100);
    chk("rr.g3", gnt[3], 4'b1000);
    chk("rr.g4", gnt[4], 4'b0001);
    for (int i = 1; i < 5; i++) chk("rr.spacing", gcyc[i] - gcyc[i-1], 2);
    repeat (8) @(negedge clk);

    // Two requesters arrive mid-burst; pointer (=1) orders req1 before req3.
    do_reset();
    base[0] = 8'h20; base[1] = 8'h50; base[2] = 8'h00; base[3] = 8'h70;
    foreach (off[i]) off[i] = 0;
    n = 0;
    foreach (gnt[i]) gnt[i] = '0;
    @(posedge clk); #1;
    drv_addr = {base[3], base[2], base[1], base[0]};
    drv_len  = {8'd1, 8'd0, 8'd1, 8'd3};
    drv_valid = 4'b0001;
    wait_grant("mix.grant0", 4'b0001);
    @(posedge clk); #1;
    drv_valid = 4'b1010;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      pend = o_ready;
      if (o_ready != 4'b0 && n < 2) begin gnt[n] = o_ready; n++; end
      if (o_rvalid != 4'b0) begin
        chk("mix.onehot", $countones(o_rvalid), 1);
        rid = 0;
        for (int b = 3; b >= 0; b--) if (o_rvalid[b]) rid = b;
        chk("mix.rdata", o_rdata, (base[rid] + 8'(off[rid])) ^ 8'hA5);
        off[rid]++;
      end
      @(posedge clk); #1;
      drv_valid = drv_valid & ~pend;
    end
    chk("mix.first", gnt[0], 4'b0010);
    chk("mix.second", gnt[1], 4'b1000);
    chk("mix.cnt0", off[0], 4);
    chk("mix.cnt1", off[1], 2);
    chk("mix.cnt2", off[2], 0);
    chk("mix.cnt3", off[3], 2);

    // Asynchronous reset two cycles into a 16-word burst.
    sel = 1'b0;
    @(posedge clk); #1;
    drv_addr[7:0] = 8'h30;
    drv_len[7:0]  = 8'd15;
    drv_valid = 4'b0001;
    wait_grant("arst.grant", 4'b0001);
    @(posedge clk); #1;
    drv_valid = 4'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 chk_all_zero("arst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk("arst.no_rsp", o_rvalid, 0);
      chk("arst.idle_busy", o_busy, 0);
    end
    @(posedge clk); #1;
    drv_addr[31:24] = 8'h90;
    drv_len[31:24]  = 8'd0;
    drv_valid = 4'b1000;
    wait_grant("arst.req3", 4'b1000);
    @(posedge clk); #1;
    drv_valid = 4'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 3) begin
        chk("arst.rvalid3", o_rvalid, 4'b1000);
        chk("arst.rdata3", o_rdata, 8'h90 ^ 8'hA5);
      end
    end
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
